// File: rtl/fmc_cfg_sequencer.sv
// Configuration/lock sequencer for the FMC N/M divide-select path in the clk_out domain.
// Latency: outputs registered; lock follows an IDLE/FAULT accept by RST_CYC + SETTLE_WRAPS*(N+1) cycles.
// Backpressure: cfg_ready high only in IDLE, LOCKED and FAULT; it drops the cycle after an accept.
module fmc_cfg_sequencer #(
    parameter int RST_CYC      = 4,
    parameter int SETTLE_WRAPS = 8,
    parameter int EXT_TIMEOUT  = 64
) (
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_n,
    input  logic [1:0] cfg_m,
    output logic       cfg_ready,
    input  logic       ext_tog,
    output logic [2:0] n_out,
    output logic [1:0] m_out,
    output logic       sel_rst_n,
    output logic       locked,
    output logic       err
);

    localparam int RW = $clog2(RST_CYC + 1);
    localparam int WW = $clog2(SETTLE_WRAPS + 1);
    localparam int TW = $clog2(EXT_TIMEOUT + 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYC - 1);
    localparam logic [WW-1:0] WRAP_LAST = WW'(SETTLE_WRAPS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(EXT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_RESET,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0]    shadow_n;
    logic [1:0]    shadow_m;
    logic [2:0]    ncnt;
    logic [RW-1:0] rcnt;
    logic [WW-1:0] wcnt;
    logic [TW-1:0] tcnt;
    logic          ext_s1;
    logic          ext_s2;
    logic          ext_s3;
    logic          ext_edge;
    logic          accept;
    logic          wrap;
    logic          timeout;
    logic          run_now;
    logic          run_next;
    logic          watch_now;
    logic          watch_next;

    // ext_tog crosses from clk_ext: two flops to resolve metastability, third for edge detect
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_s3 <= 1'b0;
        end else begin
            ext_s1 <= ext_tog;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
        end
    end

    assign ext_edge  = ext_s2 ^ ext_s3;
    assign cfg_ready = (state == ST_IDLE) || (state == ST_LOCKED) || (state == ST_FAULT);
    assign accept    = cfg_valid & cfg_ready;
    assign wrap      = (ncnt == n_out);
    // a fresh clk_ext edge in the final cycle rescues the timeout
    assign timeout   = (tcnt == TMO_LAST) & ~ext_edge;

    // ncnt keeps running across SETTLE->LOCKED->DRAIN so the old ratio finishes its period
    assign run_now    = (state == ST_DRAIN) || (state == ST_SETTLE) || (state == ST_LOCKED);
    assign run_next   = (next_state == ST_DRAIN) || (next_state == ST_SETTLE) ||
                        (next_state == ST_LOCKED);
    assign watch_now  = (state == ST_SETTLE) || (state == ST_LOCKED);
    assign watch_next = (next_state == ST_SETTLE) || (next_state == ST_LOCKED);

    // state register
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state decode; in LOCKED an accept outranks a simultaneous timeout
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_RESET;
            ST_DRAIN:  if (wrap) next_state = ST_RESET;
            ST_RESET:  if (rcnt == RST_LAST) next_state = ST_SETTLE;
            ST_SETTLE: begin
                if (timeout) begin
                    next_state = ST_FAULT;
                end else if (wrap && (wcnt == WRAP_LAST)) begin
                    next_state = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    next_state = ST_DRAIN;
                end else if (timeout) begin
                    next_state = ST_FAULT;
                end
            end
            ST_FAULT:  if (accept) next_state = ST_RESET;
            default:   next_state = ST_IDLE;
        endcase
    end

    // period, reset-length, settle-wrap and activity-timeout counters
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            ncnt <= '0;
            rcnt <= '0;
            wcnt <= '0;
            tcnt <= '0;
        end else begin
            if (run_now && run_next) begin
                ncnt <= wrap ? 3'd0 : ncnt + 3'd1;
            end else begin
                ncnt <= '0;
            end

            if ((state == ST_RESET) && (next_state == ST_RESET)) begin
                rcnt <= rcnt + 1'b1;
            end else begin
                rcnt <= '0;
            end

            if ((state == ST_SETTLE) && (next_state == ST_SETTLE)) begin
                if (wrap) begin
                    wcnt <= wcnt + 1'b1;
                end
            end else begin
                wcnt <= '0;
            end

            if (ext_edge || !(watch_now && watch_next)) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // shadow capture and registered outputs; ratio loads on RESET entry
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            shadow_n  <= '0;
            shadow_m  <= '0;
            n_out     <= '0;
            m_out     <= '0;
            sel_rst_n <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                shadow_n <= cfg_n;
                shadow_m <= cfg_m;
            end
            // from IDLE/FAULT the accept and the load share an edge, so bypass the shadow
            if ((next_state == ST_RESET) && (state != ST_RESET)) begin
                n_out <= (state == ST_DRAIN) ? shadow_n : cfg_n;
                m_out <= (state == ST_DRAIN) ? shadow_m : cfg_m;
            end
            sel_rst_n <= run_next;
            locked    <= (next_state == ST_LOCKED);
            err       <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_fmc_cfg_sequencer.sv
// Self-checking bench for fmc_cfg_sequencer: lock-latency table, multi-cycle corner sequences,
// and a randomized run against a timeline-based reference model checked every cycle.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns after the edge.
module tb_fmc_cfg_sequencer;

    localparam int RST_CYC      = 4;
    localparam int SETTLE_WRAPS = 8;
    localparam int EXT_TIMEOUT  = 64;

    logic       clk_out   = 1'b0;
    logic       rst_n     = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_n     = '0;
    logic [1:0] cfg_m     = '0;
    logic       ext_tog   = 1'b0;
    logic       cfg_ready;
    logic [2:0] n_out;
    logic [1:0] m_out;
    logic       sel_rst_n;
    logic       locked;
    logic       err;

    always #5 clk_out = ~clk_out;

    fmc_cfg_sequencer #(
        .RST_CYC      (RST_CYC),
        .SETTLE_WRAPS (SETTLE_WRAPS),
        .EXT_TIMEOUT  (EXT_TIMEOUT)
    ) dut (
        .clk_out   (clk_out),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_m     (cfg_m),
        .cfg_ready (cfg_ready),
        .ext_tog   (ext_tog),
        .n_out     (n_out),
        .m_out     (m_out),
        .sel_rst_n (sel_rst_n),
        .locked    (locked),
        .err       (err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a timeline of edge numbers. A reconfiguration started at edge t keeps
    // the select logic in reset until edge t+RST_CYC (run), locks at run+SETTLE_WRAPS*(N+1);
    // the N-count phase is (edge-run) mod (N+1); activity loss is EXT_TIMEOUT edges past the
    // later of run and the last edge that saw a synchronized ext edge.
    int       me;
    bit       m_active, m_fault, m_drain;
    int       m_run, m_lock, m_lastxe;
    int       m_nout, m_mout, m_pn, m_pm;
    bit [3:0] hist;

    int tog_period = 0;
    int tog_cnt    = 0;
    int last_chg   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {cfg_ready, n_out, m_out, sel_rst_n, locked, err};
    endfunction

    function automatic bit m_ready();
        return !m_active || m_fault || (!m_drain && me >= m_lock);
    endfunction

    function automatic logic [8:0] exp_outs();
        bit r, s, l;
        if (!m_active || m_fault) begin
            r = 1'b1; s = 1'b0; l = 1'b0;
        end else if (m_drain) begin
            r = 1'b0; s = 1'b1; l = 1'b0;
        end else begin
            s = (me >= m_run);
            l = (me >= m_lock);
            r = l;
        end
        return {r, 3'(m_nout), 2'(m_mout), s, l, m_fault};
    endfunction

    task automatic model_reset();
        me = 0; m_active = 0; m_fault = 0; m_drain = 0;
        m_run = 0; m_lock = 0; m_lastxe = 0;
        m_nout = 0; m_mout = 0; m_pn = 0; m_pm = 0; hist = '0;
    endtask

    task automatic model_start(input int e, input int n, input int m);
        m_active = 1; m_fault = 0; m_drain = 0;
        m_nout = n; m_mout = m;
        m_run  = e + RST_CYC;
        m_lock = m_run + SETTLE_WRAPS * (n + 1);
    endtask

    task automatic model_edge(input bit v, input int n, input int m, input bit tg);
        bit acc, xe, running, wrap, tmo;
        int e, refe;
        acc  = v && m_ready();
        hist = {hist[2:0], tg};
        xe   = hist[2] ^ hist[3];
        me++;
        e = me;
        running = m_active && !m_fault && (e - 1 >= m_run);
        wrap    = running && (((e - 1 - m_run) % (m_nout + 1)) == m_nout);
        refe    = (m_lastxe > m_run) ? m_lastxe : m_run;
        tmo     = running && !m_drain && (e - refe == EXT_TIMEOUT) && !xe;
        if (xe) m_lastxe = e;
        if (!m_active || m_fault) begin
            if (acc) model_start(e, n, m);
        end else if (m_drain) begin
            if (wrap) model_start(e, m_pn, m_pm);
        end else if (e - 1 >= m_lock) begin
            if (acc) begin
                m_drain = 1; m_pn = n; m_pm = m;
            end else if (tmo) begin
                m_fault = 1;
            end
        end else if (running) begin
            if (tmo) m_fault = 1;
        end
    endtask

    task automatic step(input bit v, input bit [2:0] n, input bit [1:0] m);
        cfg_valid = v; cfg_n = n; cfg_m = m;
        if (tog_period != 0) begin
            if (tog_cnt >= tog_period - 1) begin
                ext_tog = ~ext_tog; tog_cnt = 0; last_chg = me + 1;
            end else begin
                tog_cnt++;
            end
        end
        @(posedge clk_out);
        model_edge(v, int'(n), int'(m), ext_tog);
        #1;
        check($sformatf("cyc%0d {rdy,n,m,sel,lk,err}", me), 32'(outs()), 32'(exp_outs()));
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0; cfg_valid = 1'b0;
        model_reset();
        #1;
        check(name, 32'(outs()), 32'h100);
        @(negedge clk_out);
        rst_n = 1'b1;
    endtask

    // sel: 0 wait locked=1, 1 wait sel_rst_n=0, 2 wait err=1; cnt=budget on expiry
    task automatic run_until(input int sel, input int budget, output int cnt);
        cnt = budget;
        for (int k = 0; k < budget; k++) begin
            step(1'b0, 3'd0, 2'd0);
            if ((sel == 0 && locked) || (sel == 1 && !sel_rst_n) || (sel == 2 && err)) begin
                cnt = k + 1;
                break;
            end
        end
        if (cnt == budget) check("wait budget expired", 32'(sel), 32'hFFFF);
    endtask

    typedef struct {
        bit [2:0] n;
        bit [1:0] m;
        int       per;
        int       lat;
    } vec_t;

    initial begin
        vec_t vec[5];
        int a, c, low, ph;

        vec[0] = '{3'd3, 2'd2, 5, 36};
        vec[1] = '{3'd0, 2'd0, 3, 12};
        vec[2] = '{3'd7, 2'd3, 4, 68};
        vec[3] = '{3'd1, 2'd1, 7, 20};
        vec[4] = '{3'd5, 2'd0, 9, 52};

        #2;
        // lock latency, applied ratio and reset pulse width per configuration
        for (int i = 0; i < 5; i++) begin
            do_reset("reset state");
            tog_period = vec[i].per;
            step(1'b1, vec[i].n, vec[i].m);
            a   = me;
            low = (sel_rst_n == 1'b0) ? 1 : 0;
            for (int k = 0; k < 200 && !locked; k++) begin
                step(1'b0, 3'd0, 2'd0);
                if (!sel_rst_n) low++;
            end
            check($sformatf("tbl%0d lock latency", i), 32'(me - a), 32'(vec[i].lat));
            check($sformatf("tbl%0d n_out", i), 32'(n_out), 32'(vec[i].n));
            check($sformatf("tbl%0d m_out", i), 32'(m_out), 32'(vec[i].m));
            check($sformatf("tbl%0d sel_rst_n low cycles", i), 32'(low), 32'(RST_CYC));
            check($sformatf("tbl%0d cfg_ready when locked", i), 32'(cfg_ready), 32'd1);
        end

        // reconfigure N=3 -> N=1 from LOCKED while ncnt==1: two drain cycles, then reset
        do_reset("reset state");
        tog_period = 5;
        step(1'b1, 3'd3, 2'd2);
        run_until(0, 100, c);
        for (int k = 0; k < 8; k++) begin
            ph = (me - m_run) % (m_nout + 1);
            if (ph == 1) break;
            step(1'b0, 3'd0, 2'd0);
        end
        step(1'b1, 3'd1, 2'd0);
        a = me;
        check("drain locked drop", 32'(locked), 32'd0);
        check("drain cfg_ready", 32'(cfg_ready), 32'd0);
        run_until(1, 20, c);
        check("drain length", 32'(me - a), 32'd2);
        check("drain new n_out", 32'(n_out), 32'd1);
        run_until(0, 100, c);
        check("relock latency", 32'(me - a), 32'd22);

        // activity loss in LOCKED: 2 sync edges + EXT_TIMEOUT after the last change
        tog_period = 0;
        run_until(2, 200, c);
        check("fault delay", 32'(me - last_chg), 32'(EXT_TIMEOUT + 2));
        check("fault sel_rst_n", 32'(sel_rst_n), 32'd0);
        tog_period = 5;
        step(1'b1, 3'd3, 2'd2);
        a = me;
        check("fault err clears", 32'(err), 32'd0);
        run_until(0, 100, c);
        check("lock after fault", 32'(me - a), 32'd36);

        // accept lands on the timeout edge: accept wins, DRAIN, no error
        tog_period = 0;
        while (me + 1 < last_chg + EXT_TIMEOUT + 2) step(1'b0, 3'd0, 2'd0);
        step(1'b1, 3'd5, 2'd1);
        check("acc+tmo err", 32'(err), 32'd0);
        check("acc+tmo cfg_ready", 32'(cfg_ready), 32'd0);
        check("acc+tmo sel_rst_n", 32'(sel_rst_n), 32'd1);
        tog_period = 5;
        run_until(0, 200, c);

        // ext edge arrives in the final timeout cycle: no fault, count restarts
        tog_period = 0;
        while (me + 1 < last_chg + EXT_TIMEOUT) step(1'b0, 3'd0, 2'd0);
        ext_tog  = ~ext_tog;
        last_chg = me + 1;
        step(1'b0, 3'd0, 2'd0);
        step(1'b0, 3'd0, 2'd0);
        step(1'b0, 3'd0, 2'd0);
        check("edge rescue err", 32'(err), 32'd0);
        run_until(2, 200, c);
        check("rescued fault delay", 32'(me - last_chg), 32'(EXT_TIMEOUT + 2));

        // asynchronous reset in the middle of RESET and of SETTLE
        tog_period = 5;
        do_reset("reset state");
        step(1'b1, 3'd2, 2'd1);
        step(1'b0, 3'd0, 2'd0);
        do_reset("async reset in RESET");
        step(1'b1, 3'd2, 2'd1);
        for (int k = 0; k < RST_CYC + 3; k++) step(1'b0, 3'd0, 2'd0);
        check("in SETTLE sel_rst_n", 32'(sel_rst_n), 32'd1);
        do_reset("async reset in SETTLE");

        // randomized traffic with activity gaps, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                tog_period = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
            end
            step($urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
